ramp_adc_ctrl: RTL

Conversion sequencer for the single-slope ADC path. On a start request it resets the ramp, then sweeps a digital ramp code into the DAC while counting. It watches the comparator through an internal edge_sampler and captures the count when the comparator switches, with the sampler latency compensated. The result is presented on a valid/ready handshake to the capture/logging logic.

---
 rtl/adc_pkg.sv | 16 +
 rtl/ramp_adc_ctrl_edge_sampler.sv | 29 ++
 rtl/ramp_adc_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and default sizing for the single-slope ADC conversion path.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RAMP,
        HOLD
    } state_t;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SETTLE_CYCLES = 4;
    // Matches the edge_sampler pipeline depth (two sync flops + registered edge).
    localparam int DEF_LAT_COMP      = 3;

endpackage

// File: rtl/ramp_adc_ctrl_edge_sampler.sv
// Synchronises the asynchronous comparator and emits a one-cycle pulse on its
// rising edge; comparator switch to pulse is three clock cycles.
module edge_sampler (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Stage p0/p1: metastability guard; p2: previous level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
            out     <= 1'b0;
        end else begin
            sync_p0 <= in;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
            out     <= sync_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/ramp_adc_ctrl.sv
// Single-slope ADC sequencer: discharge, sweep the ramp code, capture the
// latency-compensated count on the comparator edge, hand off via valid/ready.
module ramp_adc_ctrl
    import adc_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int LAT_COMP      = DEF_LAT_COMP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             comp_in,
    output logic             ramp_rst,
    output logic             ramp_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             ovf
);

    localparam int               CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] FULL        = '1;
    localparam logic [WIDTH-1:0] LAT         = WIDTH'(LAT_COMP);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic             comp_pulse;
    logic             sampler_rst;

    // Undo the sampler delay; an early pulse cannot map below code zero.
    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] code);
        return (code < LAT) ? '0 : (code - LAT);
    endfunction

    assign sampler_rst = ~rst;

    edge_sampler u_sampler (
        .clk (clk),
        .rst (sampler_rst),
        .in  (comp_in),
        .out (comp_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ramp_rst  = 1'b0;
        ramp_en   = 1'b0;
        busy      = 1'b1;
        valid     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                ramp_rst = 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = RAMP;
                end
            end
            RAMP: begin
                ramp_en = 1'b1;
                if (comp_pulse || (dac_code == FULL)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                valid = 1'b1;
                if (ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pulse on the full-scale code takes priority over overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_code   <= '0;
            settle_cnt <= '0;
            data       <= '0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dac_code   <= '0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                RAMP: begin
                    if (comp_pulse) begin
                        data <= sat_sub(dac_code);
                        ovf  <= 1'b0;
                    end else if (dac_code == FULL) begin
                        data <= FULL;
                        ovf  <= 1'b1;
                    end else begin
                        dac_code <= dac_code + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
